// File: rtl/pld_bus_pkg.sv
// Shared definitions for the PLD parallel bus.
// Holds the master FSM state encoding, the default phase lengths, the
// slave-side register address map and a helper that clamps a phase
// length into the 1..255 range the phase timer works with.
package pld_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } pld_state_e;

    localparam int PLD_SETUP_CYC_DEF  = 4;
    localparam int PLD_STROBE_CYC_DEF = 8;
    localparam int PLD_HOLD_CYC_DEF   = 4;

    localparam logic [7:0] PLD_ADDR_IND       = 8'h08;
    localparam logic [7:0] PLD_ADDR_DAC_LO    = 8'h0A;
    localparam logic [7:0] PLD_ADDR_DAC_HI    = 8'h0B;
    localparam logic [7:0] PLD_ADDR_RELE_0    = 8'h0C;
    localparam logic [7:0] PLD_ADDR_RELE_1    = 8'h0D;
    localparam logic [7:0] PLD_ADDR_IVI_FREQ  = 8'h14;
    localparam logic [7:0] PLD_ADDR_IVI_PHASE = 8'h18;
    localparam logic [7:0] PLD_ADDR_IVI_USER  = 8'h1C;

    // A zero-length phase would never end on the "counter reaches 1" rule,
    // so 0 (and anything negative) is promoted to a single cycle.
    function automatic logic [7:0] phase_len(input int cyc);
        if (cyc <= 0)
            return 8'd1;
        else if (cyc > 255)
            return 8'd255;
        else
            return 8'(cyc);
    endfunction

endpackage

// File: rtl/pld_bus_master_if.sv
// Request/response handshake plus the PLD bus pins of pld_bus_master.
// master modport: the bus master itself.
// slave  modport: the requester together with the bus-side pad/slave.
interface pld_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [7:0]  req_addr;
    logic [7:0]  req_data;
    logic [1:0]  req_len;
    logic        rsp_valid;
    logic [31:0] rsp_word;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_data_o;
    logic        bus_data_oe;
    logic [7:0]  bus_data_i;
    logic        bus_wr;
    logic        bus_rd;

    modport master (
        input  req_valid, req_wr, req_addr, req_data, req_len, bus_data_i,
        output req_ready, rsp_valid, rsp_word,
        output bus_addr, bus_data_o, bus_data_oe, bus_wr, bus_rd
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_data, req_len, bus_data_i,
        input  req_ready, rsp_valid, rsp_word,
        input  bus_addr, bus_data_o, bus_data_oe, bus_wr, bus_rd
    );
endinterface

// File: rtl/pld_bus_phase_timer.sv
// 8-bit loadable down-counter timing one bus phase.
// Ports: clk, rst_n_wire (async, active-low), load / load_val (start a phase,
// 0 treated as 1), done (high during the last cycle of the phase).
module pld_bus_phase_timer (
    input  logic       clk,
    input  logic       rst_n_wire,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n_wire) begin
        if (!rst_n_wire)
            cnt <= 8'd0;
        else if (load)
            cnt <= (load_val == 8'd0) ? 8'd1 : load_val;
        else if (cnt > 8'd1)
            cnt <= cnt - 8'd1;
    end

    assign done = (cnt == 8'd1);
endmodule

// File: rtl/pld_bus_master.sv
// Initiator for the 8-bit PLD bus: single write cycles and 1..4 byte read
// bursts with programmable setup / strobe / hold phases.
// Ports: clk, rst_n_wire (async, active-low), pif (master modport: request
// handshake, response word, bus address/data/strobes). The Data tristate
// buffer sits in the instantiating top, driven from bus_data_o/bus_data_oe.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | address (and write data) driven, strobe low
// STROBE | bus_wr or bus_rd high
// HOLD   | strobe low, address/data held; next byte or finish
// DONE   | rsp_valid pulse
module pld_bus_master
    import pld_bus_pkg::*;
#(
    parameter int SETUP_CYC  = PLD_SETUP_CYC_DEF,
    parameter int STROBE_CYC = PLD_STROBE_CYC_DEF,
    parameter int HOLD_CYC   = PLD_HOLD_CYC_DEF
) (
    input logic              clk,
    input logic              rst_n_wire,
    pld_bus_master_if.master pif
);
    localparam logic [7:0] SETUP_V  = phase_len(SETUP_CYC);
    localparam logic [7:0] STROBE_V = phase_len(STROBE_CYC);
    localparam logic [7:0] HOLD_V   = phase_len(HOLD_CYC);

    pld_state_e  state;
    logic        req_ready_q, rsp_valid_q;
    logic [31:0] rsp_word_q;
    logic [7:0]  bus_addr_q, bus_data_q;
    logic        bus_oe_q, bus_wr_q, bus_rd_q;
    logic        wr_l;
    logic [7:0]  addr_l;
    logic [1:0]  len_l, idx;
    logic        accept, tmr_load, tmr_done;
    logic [7:0]  tmr_val;

    assign accept = pif.req_valid && req_ready_q;

    // Timer is reloaded on the same edge that moves the FSM into a phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SETUP_V;
        case (state)
            ST_IDLE:   if (accept)   begin tmr_load = 1'b1; tmr_val = SETUP_V;  end
            ST_SETUP:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = STROBE_V; end
            ST_STROBE: if (tmr_done) begin tmr_load = 1'b1; tmr_val = HOLD_V;   end
            ST_HOLD:   if (tmr_done && idx != len_l) begin
                tmr_load = 1'b1;
                tmr_val  = SETUP_V;
            end
            default: ;
        endcase
    end

    pld_bus_phase_timer u_timer (
        .clk        (clk),
        .rst_n_wire (rst_n_wire),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .done       (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n_wire) begin
        if (!rst_n_wire) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_word_q  <= 32'd0;
            bus_addr_q  <= 8'd0;
            bus_data_q  <= 8'd0;
            bus_oe_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_rd_q    <= 1'b0;
            wr_l        <= 1'b0;
            addr_l      <= 8'd0;
            len_l       <= 2'd0;
            idx         <= 2'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_SETUP;
                        req_ready_q <= 1'b0;
                        wr_l        <= pif.req_wr;
                        addr_l      <= pif.req_addr;
                        len_l       <= pif.req_wr ? 2'd0 : pif.req_len;
                        idx         <= 2'd0;
                        bus_addr_q  <= pif.req_addr;
                        bus_data_q  <= pif.req_wr ? pif.req_data : 8'd0;
                        bus_oe_q    <= pif.req_wr;
                        if (!pif.req_wr)
                            rsp_word_q <= 32'd0;
                    end else begin
                        // First cycle after reset release raises ready here.
                        req_ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        state    <= ST_STROBE;
                        bus_wr_q <= wr_l;
                        bus_rd_q <= !wr_l;
                    end
                end
                ST_STROBE: begin
                    if (tmr_done) begin
                        state    <= ST_HOLD;
                        bus_wr_q <= 1'b0;
                        bus_rd_q <= 1'b0;
                        if (!wr_l)
                            rsp_word_q[{idx, 3'b000} +: 8] <= pif.bus_data_i;
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) begin
                        if (idx != len_l) begin
                            state      <= ST_SETUP;
                            idx        <= idx + 2'd1;
                            bus_addr_q <= addr_l + {6'd0, idx + 2'd1};
                        end else begin
                            state       <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                            bus_oe_q    <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pif.req_ready   = req_ready_q;
    assign pif.rsp_valid   = rsp_valid_q;
    assign pif.rsp_word    = rsp_word_q;
    assign pif.bus_addr    = bus_addr_q;
    assign pif.bus_data_o  = bus_data_q;
    assign pif.bus_data_oe = bus_oe_q;
    assign pif.bus_wr      = bus_wr_q;
    assign pif.bus_rd      = bus_rd_q;
endmodule

// File: tb/tb_pld_bus_master.sv
module tb_pld_bus_master;
    localparam int S = 4, T = 8, H = 4, P = S + T + H;

    logic clk = 1'b0;
    logic rst_n_wire = 1'b0;
    int   n_chk = 0, n_err = 0;
    logic [31:0] last_rsp = 32'd0;
    logic [7:0]  slave_regs [256];

    pld_bus_master_if pif ();

    pld_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
        .clk        (clk),
        .rst_n_wire (rst_n_wire),
        .pif        (pif)
    );

    always #10 clk = ~clk;

    // Slave model: reads return addr + 0x30, writes land in a register array.
    assign pif.bus_data_i = pif.bus_addr + 8'h30;

    always @(posedge clk)
        if (pif.bus_wr) slave_regs[pif.bus_addr] <= pif.bus_data_o;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (rst_n_wire) begin
            chk("wr_rd_excl", {31'd0, pif.bus_wr & pif.bus_rd}, 32'd0);
            if (!pif.bus_data_oe) chk("wr_without_oe", {31'd0, pif.bus_wr}, 32'd0);
        end

    // One request end to end; cycle c counts from the accept edge (c = 0).
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                           input logic [1:0] len, input bit hold, input bit scramble);
        int n, np, k, i, ph;
        logic [31:0] exp_word;
        logic        strobe;
        n  = wr ? 1 : int'(len) + 1;
        np = n * P;
        exp_word = 32'd0;
        for (int b = 0; b < n; b++)
            exp_word[b*8 +: 8] = addr + 8'(b) + 8'h30;
        pif.req_wr = wr; pif.req_addr = addr; pif.req_data = data; pif.req_len = len;
        pif.req_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            if (pif.req_ready) break;
            @(negedge clk);
        end
        if (k == 200) begin
            chk("ready_timeout", 32'd0, 32'd1);
            pif.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) pif.req_valid = 1'b0;
        for (int c = 1; c <= np + 2; c++) begin
            @(negedge clk);
            if (scramble) pif.req_data = ~data ^ 8'(c);
            if (c <= np) begin
                i  = (c - 1) / P;
                ph = (c - 1) % P;
                strobe = (ph >= S) && (ph < S + T);
                chk("bus_addr", {24'd0, pif.bus_addr}, {24'd0, addr + 8'(i)});
                chk("bus_oe", {31'd0, pif.bus_data_oe}, {31'd0, wr});
                chk("bus_wr", {31'd0, pif.bus_wr}, {31'd0, wr & strobe});
                chk("bus_rd", {31'd0, pif.bus_rd}, {31'd0, ~wr & strobe});
                if (wr) chk("bus_data_o", {24'd0, pif.bus_data_o}, {24'd0, data});
            end else begin
                chk("idle_strobes", {30'd0, pif.bus_wr, pif.bus_rd}, 32'd0);
            end
            chk("rsp_valid", {31'd0, pif.rsp_valid}, {31'd0, c == np + 1});
            chk("req_ready", {31'd0, pif.req_ready}, {31'd0, c == np + 2});
            if (c == np + 1) begin
                if (!wr) last_rsp = exp_word;
                chk("rsp_word", pif.rsp_word, last_rsp);
            end
        end
        if (wr) chk("slave_reg", {24'd0, slave_regs[addr]}, {24'd0, data});
    endtask

    initial begin
        logic        r_wr;
        logic [7:0]  r_addr, r_data;
        logic [1:0]  r_len;
        pif.req_valid = 1'b1; pif.req_wr = 1'b0; pif.req_addr = 8'd0;
        pif.req_data = 8'd0; pif.req_len = 2'd0;

        // Reset held with a pending request
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, pif.req_ready}, 32'd0);
        chk("rst_outs", {pif.bus_addr, pif.bus_data_o, 4'd0, pif.bus_data_oe,
                         pif.bus_wr, pif.bus_rd, pif.rsp_valid, 8'd0}, 32'd0);
        chk("rst_word", pif.rsp_word, 32'd0);
        rst_n_wire = 1'b1;
        pif.req_valid = 1'b0;
        @(negedge clk);
        chk("rel_ready", {31'd0, pif.req_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rel_quiet", {29'd0, pif.bus_wr, pif.bus_rd, pif.bus_data_oe}, 32'd0);
        end

        // Directed cases
        run_txn(1'b1, 8'h08, 8'hA5, 2'd0, 1'b0, 1'b0);
        chk("ind_reg", {24'd0, slave_regs[8'h08]}, 32'h0000_00A5);
        run_txn(1'b0, 8'h14, 8'h00, 2'd3, 1'b0, 1'b0);
        chk("ivi_word", pif.rsp_word, 32'h4746_4544);
        run_txn(1'b0, 8'hFF, 8'h00, 2'd1, 1'b0, 1'b0);
        chk("wrap_word", pif.rsp_word, 32'h0000_302F);

        // Back-to-back writes with req_valid held and req_data disturbed while busy
        run_txn(1'b1, 8'h0A, 8'h5A, 2'd0, 1'b1, 1'b1);
        run_txn(1'b1, 8'h0B, 8'hC3, 2'd0, 1'b0, 1'b1);

        // Reset in cycle 7 of a write
        pif.req_wr = 1'b1; pif.req_addr = 8'h0C; pif.req_data = 8'h3C; pif.req_len = 2'd0;
        pif.req_valid = 1'b1;
        @(posedge clk);
        #1 pif.req_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_wr", {31'd0, pif.bus_wr}, 32'd1);
        rst_n_wire = 1'b0;
        #1;
        chk("async_wr", {31'd0, pif.bus_wr}, 32'd0);
        chk("async_oe", {31'd0, pif.bus_data_oe}, 32'd0);
        chk("async_addr", {24'd0, pif.bus_addr}, 32'd0);
        last_rsp = 32'd0;
        repeat (2) @(negedge clk);
        rst_n_wire = 1'b1;
        @(negedge clk);
        chk("rst2_ready", {31'd0, pif.req_ready}, 32'd1);
        repeat (20) begin
            @(negedge clk);
            chk("no_rsp", {31'd0, pif.rsp_valid}, 32'd0);
        end

        // Randomized requests
        for (int t = 0; t < 24; t++) begin
            r_wr   = 1'($urandom);
            r_addr = 8'($urandom);
            r_data = 8'($urandom);
            r_len  = 2'($urandom);
            run_txn(r_wr, r_addr, r_data, r_len, 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pld_bus_master.md
# pld_bus_master

Initiator for the board's 8-bit parallel PLD bus (Addr / Data / wr_pld / rd_pld). It turns single requests into timed write or read cycles with programmable setup, strobe and hold phases. Reads of 1–4 consecutive bytes are packed into a 32-bit word, which covers the 4-byte intervalometer readouts. It is used as the test-jig or second-FPGA driver of the existing bus slave, and as the bus-functional master in its benches.

## Interface
- SETUP_CYC, 4: clk cycles that address and write data are stable before the strobe. Range 1–255; 0 is treated as 1.
- STROBE_CYC, 8: clk cycles the strobe is high. Must exceed the slave's sync and decode latency. Range 1–255; 0 is treated as 1.
- HOLD_CYC, 4: clk cycles that address and data stay stable after the strobe falls. Range 1–255; 0 is treated as 1.
- clk  in  1  50 MHz system clock.
- rst_n_wire  in  1  Reset, asynchronous, active-low.
- req_valid  in  1  Request present.
- req_ready  out  1  High in IDLE only. A request is accepted when req_valid && req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  8  Start address.
- req_data  in  8  Write byte. Used only when req_wr = 1.
- req_len  in  2  Read byte count minus 1 (0–3 gives 1–4 bytes). Forced to 0 for writes.
- rsp_valid  out  1  One-cycle pulse on completion, for reads and writes.
- rsp_word  out  32  Read result. The byte from req_addr is in [7:0]. Unused upper bytes are 0. Unchanged by writes.
- bus_addr  out  8  Drives Addr.
- bus_data_o  out  8  Write data toward the Data pad.
- bus_data_oe  out  1  Output enable for the Data tristate.
- bus_data_i  in  8  Data pad input.
- bus_wr  out  1  wr_pld strobe, active-high.
- bus_rd  out  1  rd_pld strobe, active-high.

## Operation
- States:
  - IDLE: req_ready = 1.
  - SETUP: address and data driven, strobe low.
  - STROBE: strobe high.
  - HOLD: strobe low, address and data held.
  - DONE: rsp_valid = 1.
- Transitions:
  - IDLE to SETUP on accept. req_wr, req_addr, req_data and req_len are latched at that point.
  - SETUP to STROBE after SETUP_CYC cycles.
  - STROBE to HOLD after STROBE_CYC cycles.
  - HOLD to SETUP after HOLD_CYC cycles if bytes remain, otherwise to DONE.
  - DONE to IDLE after 1 cycle.
- A single phase down-counter is loaded on entry to each phase. The phase ends when the counter reaches 1.
- Byte index i runs from 0 to len. bus_addr = latched addr + i, modulo 256, so 0xFF wraps to 0x00.
- Write cycle: bus_data_o = latched data. bus_data_oe = 1 from SETUP through HOLD. bus_wr pulses during STROBE.
- Read cycle: bus_data_oe = 0 throughout. bus_rd pulses during STROBE. bus_data_i is registered into rsp_word byte i on the clock edge that ends the last STROBE cycle.
- rsp_word is cleared to 0 on accept of a read.
- bus_wr and bus_rd are never high together. Neither is high outside STROBE.
- req_valid is ignored while not in IDLE. The requester holds the request until it is accepted.
- Reset values:
  - req_ready = 1 after release.
  - rsp_valid, rsp_word, bus_addr, bus_data_o, bus_data_oe, bus_wr, bus_rd = 0.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously). The transaction is dropped and no rsp_valid is produced.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The accept edge is cycle 0. Let P = SETUP_CYC + STROBE_CYC + HOLD_CYC and N = number of bytes.
- For byte i:
  - SETUP occupies cycles i·P+1 to i·P+SETUP_CYC.
  - STROBE occupies the next STROBE_CYC cycles.
  - HOLD occupies the next HOLD_CYC cycles.
- rsp_valid is high in cycle N·P+1. req_ready is high again from cycle N·P+2.
- Throughput for back-to-back requests: one request per N·P+2 cycles.

## Structure
- Shared package pld_bus_pkg holds:
  - the state encoding;
  - the default SETUP/STROBE/HOLD constants;
  - the bus address map used by the slave: IND = 0x08, DAC_LO = 0x0A, DAC_HI = 0x0B, RELE = 0x0C/0x0D, IVI_FREQ = 0x14, IVI_PHASE = 0x18, IVI_USER = 0x1C.
- One sub-module: pld_bus_phase_timer, an 8-bit loadable down-counter with a done flag.
- The tristate pad stays at the top level and is driven from bus_data_o and bus_data_oe.

## Test plan
- Reset: hold rst_n_wire low with req_valid = 1 → all outputs 0, req_ready = 0. After release, req_ready = 1 and there is no bus activity.
- Write 0xA5 to 0x08, default parameters:
  - bus_addr = 0x08 and bus_data_oe = 1 in cycles 1–16;
  - bus_wr = 1 in cycles 5–12;
  - rsp_valid in cycle 17, req_ready in cycle 18;
  - the slave model's Ind register reads 0xA5.
- Read req_len = 3 at 0x14, with a model returning addr + 0x30 → bus_rd pulses 4 times on addresses 0x14–0x17. rsp_word = 0x47464544, rsp_valid in cycle 65.
- Wrap: read req_len = 1 at 0xFF → addresses 0xFF then 0x00, rsp_word = 0x0000302F.
- Reset asserted in cycle 7 of a write → bus_wr and bus_data_oe drop with no clock edge needed, no rsp_valid is produced, and req_ready = 1 after release.
- Back-to-back: hold req_valid high across two writes → the second is accepted at cycle 18. Changes to req_data while busy do not affect bus_data_o. bus_wr and bus_rd never overlap (checked by assertion).
